// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: half/one coins, programmable price, change, stock and restock.
// Optional feature: define VEND_CANCEL_EN to make pi_cancel refund the credit.
module vend_fsm_param #(
   parameter int PRICE    = 5,
   parameter int CREDIT_W = 4,
   parameter int STOCK    = 8,
   parameter int STOCK_W  = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                pi_coin_half,
   input  logic                pi_coin_one,
   input  logic                pi_cancel,
   input  logic                pi_restock,
   output logic                po_cola,
   output logic [CREDIT_W-1:0] po_change,
   output logic                po_change_vld,
   output logic                po_soldout,
   output logic [CREDIT_W-1:0] po_credit,
   output logic [1:0]          fsm_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAY     = 2'd1,
      SOLDOUT = 2'd2
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK);
   localparam logic [STOCK_W-1:0]  ONE_C   = STOCK_W'(1);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [STOCK_W-1:0]  stock_q, stock_d;
   logic                cola_q, cola_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                vld_q, vld_d;
   logic [CREDIT_W-1:0] add, sum;
   logic                cancel_act;

`ifdef VEND_CANCEL_EN
   assign cancel_act = pi_cancel;
`else
   logic unused_cancel;
   assign unused_cancel = pi_cancel;
   assign cancel_act    = 1'b0;
`endif

   // {one, half} read as a binary number is exactly the half-unit value added.
   assign add = CREDIT_W'({pi_coin_one, pi_coin_half});
   assign sum = credit_q + add;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         credit_q <= '0;
         stock_q  <= STOCK_C;
         cola_q   <= 1'b0;
         change_q <= '0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         stock_q  <= stock_d;
         cola_q   <= cola_d;
         change_q <= change_d;
         vld_q    <= vld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      stock_d  = stock_q;
      cola_d   = 1'b0;
      change_d = '0;
      vld_d    = 1'b0;
      case (state_q)
         IDLE, PAY: begin
            if (cancel_act) begin
               change_d = sum;
               vld_d    = (sum != '0);
               credit_d = '0;
               state_d  = IDLE;
            end else if (sum >= PRICE_C) begin
               cola_d   = 1'b1;
               change_d = sum - PRICE_C;
               vld_d    = (sum != PRICE_C);
               credit_d = '0;
               stock_d  = stock_q - ONE_C;
               state_d  = (stock_q == ONE_C) ? SOLDOUT : IDLE;
            end else if (sum != '0) begin
               credit_d = sum;
               state_d  = PAY;
            end
         end
         SOLDOUT: begin
            // Coins are never credited here; whatever arrives goes straight back.
            change_d = add;
            vld_d    = (add != '0);
         end
         default: state_d = IDLE;
      endcase
      // Restock wins over a same-cycle sell-out, so the machine lands in IDLE.
      if (pi_restock) begin
         stock_d = STOCK_C;
         if (state_d == SOLDOUT) state_d = IDLE;
      end
   end

   // po_change carries a value only in the cycle po_change_vld pulses; it is 0 otherwise.
   assign po_cola       = cola_q;
   assign po_change     = change_q;
   assign po_change_vld = vld_q;
   assign po_soldout    = (state_q == SOLDOUT);
   assign po_credit     = credit_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed, table-driven bench for vend_fsm_param (PRICE=5, STOCK=2), plus hand-written sequences.
module tb_vend_fsm_param;

   logic       clk;
   logic       sys_rst, coin_half, coin_one, cancel, restock;
   logic       cola, change_vld, soldout;
   logic [3:0] change, credit;
   logic [1:0] fsm_state;

   int tests;
   int fails;

   typedef struct {
      logic       rst, half, one, cncl, rstk;
      logic       cola;
      logic [3:0] chg;
      logic       vld, so;
      logic [3:0] cr;
   } vec_t;

   vec_t exp_q[$];

   vend_fsm_param #(.PRICE(5), .CREDIT_W(4), .STOCK(2), .STOCK_W(4)) dut (
      .sys_clk       (clk),
      .sys_rst       (sys_rst),
      .pi_coin_half  (coin_half),
      .pi_coin_one   (coin_one),
      .pi_cancel     (cancel),
      .pi_restock    (restock),
      .po_cola       (cola),
      .po_change     (change),
      .po_change_vld (change_vld),
      .po_soldout    (soldout),
      .po_credit     (credit),
      .fsm_state     (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic rst, h, o, c, r, input logic ec, input logic [3:0] ech,
                       input logic ev, es, input logic [3:0] ecr);
      vec_t v;
      v.rst = rst; v.half = h; v.one = o; v.cncl = c; v.rstk = r;
      v.cola = ec; v.chg = ech; v.vld = ev; v.so = es; v.cr = ecr;
      exp_q.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // One cycle: drive at negedge, sample 1 ns after the posedge, drop the pulses.
   task automatic apply_check(input string tag, input vec_t v);
      @(negedge clk);
      sys_rst = v.rst; coin_half = v.half; coin_one = v.one; cancel = v.cncl; restock = v.rstk;
      @(posedge clk);
      #1;
      check({tag, " cola"}, {7'd0, cola}, {7'd0, v.cola});
      check({tag, " change"}, {4'd0, change}, {4'd0, v.chg});
      check({tag, " vld"}, {7'd0, change_vld}, {7'd0, v.vld});
      check({tag, " soldout"}, {7'd0, soldout}, {7'd0, v.so});
      check({tag, " credit"}, {4'd0, credit}, {4'd0, v.cr});
      sys_rst = 1'b0; coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0; restock = 1'b0;
   endtask

   task automatic step(input string tag, input logic rst, h, o, c, r, input logic ec,
                       input logic [3:0] ech, input logic ev, es, input logic [3:0] ecr);
      vec_t v;
      v.rst = rst; v.half = h; v.one = o; v.cncl = c; v.rstk = r;
      v.cola = ec; v.chg = ech; v.vld = ev; v.so = es; v.cr = ecr;
      apply_check(tag, v);
   endtask

   initial begin
      tests = 0; fails = 0;
      sys_rst = 1'b1; coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0; restock = 1'b0;

      //   rst h o c r   cola chg vld so cr
      push(1, 0,0,0,0,  0, 0, 0, 0, 0);   // reset state
      // half, one, one: vend exact price, stock 2->1
      push(0, 1,0,0,0,  0, 0, 0, 0, 1);
      push(0, 0,1,0,0,  0, 0, 0, 0, 3);
      push(0, 0,1,0,0,  1, 0, 0, 0, 0);
      push(0, 0,0,0,0,  0, 0, 0, 0, 0);
      // credit 4 then half+one together: sum 7, change 2, stock 1->0
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 0,1,0,0,  0, 0, 0, 0, 4);
      push(0, 1,1,0,0,  1, 2, 1, 1, 0);
      // sold out: coins refunded, never credited
      push(0, 0,1,0,0,  0, 2, 1, 1, 0);
      push(0, 1,1,0,0,  0, 3, 1, 1, 0);
      push(0, 0,0,0,0,  0, 0, 0, 1, 0);
      // restock with a coin in the same cycle: coin still refunded, back to IDLE
      push(0, 1,0,0,1,  0, 1, 1, 0, 0);
      push(0, 0,0,0,0,  0, 0, 0, 0, 0);
      // credit 3, then cancel+half
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 1,0,0,0,  0, 0, 0, 0, 3);
`ifdef VEND_CANCEL_EN
      push(0, 1,0,1,0,  0, 4, 1, 0, 0);
`else
      push(0, 1,0,1,0,  0, 0, 0, 0, 4);
`endif
      push(1, 0,0,0,0,  0, 0, 0, 0, 0);
      // credit 4, then cancel+one
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 0,1,0,0,  0, 0, 0, 0, 4);
`ifdef VEND_CANCEL_EN
      push(0, 0,1,1,0,  0, 6, 1, 0, 0);
`else
      push(0, 0,1,1,0,  1, 1, 1, 0, 0);
`endif
      // follow-up purchase: sells out only if the cancel above vended
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 0,1,0,0,  0, 0, 0, 0, 4);
`ifdef VEND_CANCEL_EN
      push(0, 0,1,0,0,  1, 1, 1, 0, 0);
`else
      push(0, 0,1,0,0,  1, 1, 1, 1, 0);
`endif
      push(1, 0,0,0,0,  0, 0, 0, 0, 0);
      // reset mid-purchase discards credit; next purchase needs the full price
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 1,0,0,0,  0, 0, 0, 0, 3);
      push(1, 0,0,0,0,  0, 0, 0, 0, 0);
      push(0, 0,1,0,0,  0, 0, 0, 0, 2);
      push(0, 0,1,0,0,  0, 0, 0, 0, 4);
      push(0, 1,0,0,0,  1, 0, 0, 0, 0);

      for (int i = 0; i < exp_q.size(); i++)
         apply_check($sformatf("row%0d", i), exp_q[i]);

      // Reset held two cycles while coins arrive: nothing is credited.
      step("rst_hold0", 1, 0,1,0,0,  0, 0, 0, 0, 0);
      step("rst_hold1", 1, 1,1,0,0,  0, 0, 0, 0, 0);
      // Restock during PAY keeps credit; stock reloaded to 2.
      step("pay_a",     0, 1,0,0,0,  0, 0, 0, 0, 1);
      step("pay_rstk",  0, 0,1,0,1,  0, 0, 0, 0, 3);
      step("pay_vend",  0, 0,1,0,0,  1, 0, 0, 0, 0);
      // Second purchase after the reload empties stock.
      step("last_a",    0, 1,1,0,0,  0, 0, 0, 0, 3);
      step("last_vend", 0, 1,1,0,0,  1, 1, 1, 1, 0);
      step("so_idle",   0, 0,0,0,0,  0, 0, 0, 1, 0);
      step("so_cancel", 0, 1,0,1,0,  0, 1, 1, 1, 0);
      step("so_rstk",   0, 0,0,0,1,  0, 0, 0, 0, 0);
      step("after_a",   0, 0,1,0,0,  0, 0, 0, 0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
